// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the register file
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = $clog2(NUM_REGS);
   localparam int SP_INDEX = 29;
   localparam int SP_RESET = 252;
   typedef logic [ADDR_W-1:0] reg_idx_t;
   localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-load bits with set priority, per-port lookup and any-pending flag
module reg_scoreboard import regfile_pkg::*; #(
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_READ = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       reserve,
   input  logic [ADDR_W-1:0]          reserve_idx,
   input  logic                       clear,
   input  logic [ADDR_W-1:0]          clear_idx,
   input  logic [NUM_READ*ADDR_W-1:0] lookup_idx,
   output logic [NUM_READ-1:0]        lookup_busy,
   output logic                       pending
);
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   // clear before set so a new load issued as the old one returns stays pending
   always_comb begin
      busy_d = busy_q;
      if (clear) busy_d[clear_idx] = 1'b0;
      if (reserve && reserve_idx != ADDR_W'(ZERO_REG)) busy_d[reserve_idx] = 1'b1;
      busy_d[0] = 1'b0;
   end
   // lookups see the post-update bits so readers get this cycle's set/clear
   always_comb begin
      lookup_busy = '0;
      for (int i = 0; i < NUM_READ; i++) lookup_busy[i] = busy_d[lookup_idx[i*ADDR_W +: ADDR_W]];
   end
   // scoreboard state and registered any-pending flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         pending <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         pending <= |busy_d;
      end
   end
endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: register file with N forwarded synchronous read ports, two write ports and a load scoreboard
module multiport_regfile import regfile_pkg::*; #(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_READ = 2,
   parameter int SP_INDEX = regfile_pkg::SP_INDEX,
   parameter int SP_RESET = regfile_pkg::SP_RESET
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic [NUM_READ*ADDR_W-1:0] ReadRegister,
   input  logic [NUM_READ-1:0]        ReadEnable,
   output logic [NUM_READ*DATA_W-1:0] ReadData,
   output logic [NUM_READ-1:0]        ReadBusy,
   input  logic [ADDR_W-1:0]          WriteRegisterA,
   input  logic [DATA_W-1:0]          WriteDataA,
   input  logic                       RegWriteA,
   input  logic [ADDR_W-1:0]          WriteRegisterB,
   input  logic [DATA_W-1:0]          WriteDataB,
   input  logic                       RegWriteB,
   input  logic                       Reserve,
   input  logic [ADDR_W-1:0]          ReserveRegister,
   output logic                       PendingAny
);
   logic              wr_a;
   logic              wr_b;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [NUM_READ-1:0] busy_d;
   assign wr_a = RegWriteA && WriteRegisterA != ADDR_W'(ZERO_REG);
   assign wr_b = RegWriteB && WriteRegisterB != ADDR_W'(ZERO_REG);
   // post-write register image: load return beats ALU on the same index, register 0 stays zero
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++)
         regs_d[r] = (r == 0) ? '0 :
                     (wr_b && WriteRegisterB == ADDR_W'(r)) ? WriteDataB :
                     (wr_a && WriteRegisterA == ADDR_W'(r)) ? WriteDataA : regs_q[r];
   end
   // storage; the stack pointer leaves reset at its initial value
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= (r == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      end else begin
         regs_q <= regs_d;
      end
   end
   reg_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ)) u_sb (
      .clk(Clk),
      .rst_n(Reset_n),
      .reserve(Reserve),
      .reserve_idx(ReserveRegister),
      .clear(RegWriteB),
      .clear_idx(WriteRegisterB),
      .lookup_idx(ReadRegister),
      .lookup_busy(busy_d),
      .pending(PendingAny)
   );
   for (genvar i = 0; i < NUM_READ; i++) begin : g_read
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data_q;
      logic              busy_q;
      assign idx = ReadRegister[i*ADDR_W +: ADDR_W];
      // registered read with same-cycle forwarding; holds while not enabled
      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n) begin
            data_q <= '0;
            busy_q <= 1'b0;
         end else if (ReadEnable[i]) begin
            data_q <= regs_d[idx];
            busy_q <= busy_d[i];
         end
      end
      assign ReadData[i*DATA_W +: DATA_W] = data_q;
      assign ReadBusy[i] = busy_q;
   end
endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile: directed and randomized checks against an array-based reference model
module tb_multiport_regfile;
   localparam int DW = 32, NR = 32, AW = 5, NRD = 2;
   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic [NRD*AW-1:0] ReadRegister;
   logic [NRD-1:0]    ReadEnable;
   logic [NRD*DW-1:0] ReadData;
   logic [NRD-1:0]    ReadBusy;
   logic [AW-1:0]     WriteRegisterA, WriteRegisterB, ReserveRegister;
   logic [DW-1:0]     WriteDataA, WriteDataB;
   logic              RegWriteA, RegWriteB, Reserve, PendingAny;
   int vectors = 0;
   int errors = 0;
   logic [DW-1:0] m_mem [NR];
   bit            m_sb [NR];
   logic [DW-1:0] m_rd [NRD];
   bit            m_busy [NRD];
   bit            m_pend;

   always #5 Clk = ~Clk;

   multiport_regfile #(.DATA_W(DW), .NUM_REGS(NR), .NUM_READ(NRD)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .ReadRegister(ReadRegister), .ReadEnable(ReadEnable),
      .ReadData(ReadData), .ReadBusy(ReadBusy),
      .WriteRegisterA(WriteRegisterA), .WriteDataA(WriteDataA), .RegWriteA(RegWriteA),
      .WriteRegisterB(WriteRegisterB), .WriteDataB(WriteDataB), .RegWriteB(RegWriteB),
      .Reserve(Reserve), .ReserveRegister(ReserveRegister),
      .PendingAny(PendingAny)
   );

   task automatic model_reset();
      for (int r = 0; r < NR; r++) begin
         m_mem[r] = '0;
         m_sb[r] = 0;
      end
      m_mem[29] = 252;
      for (int i = 0; i < NRD; i++) begin
         m_rd[i] = '0;
         m_busy[i] = 0;
      end
      m_pend = 0;
   endtask

   task automatic idle();
      ReadRegister = '0; ReadEnable = '0;
      WriteRegisterA = '0; WriteDataA = '0; RegWriteA = 0;
      WriteRegisterB = '0; WriteDataB = '0; RegWriteB = 0;
      Reserve = 0; ReserveRegister = '0;
   endtask

   task automatic set_read(input int p, input int idx);
      ReadRegister[p*AW +: AW] = AW'(idx);
      ReadEnable[p] = 1'b1;
   endtask

   // one clock edge; the model applies the architectural rules to the inputs seen at that edge
   task automatic tick();
      int ra;
      @(posedge Clk);
      if (RegWriteA && WriteRegisterA != 0) m_mem[WriteRegisterA] = WriteDataA;
      if (RegWriteB && WriteRegisterB != 0) m_mem[WriteRegisterB] = WriteDataB;
      if (RegWriteB) m_sb[WriteRegisterB] = 0;
      if (Reserve && ReserveRegister != 0) m_sb[ReserveRegister] = 1;
      for (int i = 0; i < NRD; i++) begin
         if (ReadEnable[i]) begin
            ra = int'(ReadRegister[i*AW +: AW]);
            m_rd[i] = (ra == 0) ? '0 : m_mem[ra];
            m_busy[i] = (ra == 0) ? 0 : m_sb[ra];
         end
      end
      m_pend = 0;
      for (int r = 0; r < NR; r++) m_pend |= m_sb[r];
      #1;
   endtask

   task automatic test_reset();
      idle();
      model_reset();
      #12;
      vectors++;
      if (ReadData !== '0 || ReadBusy !== '0 || PendingAny !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: data=%h busy=%b pend=%b want 0/0/0", ReadData, ReadBusy, PendingAny);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      set_read(0, 29);
      set_read(1, 5);
      tick();
      vectors++;
      if (ReadData[0 +: DW] !== 32'd252) begin errors++; $display("FAIL reset_sp: got %h want %h", ReadData[0 +: DW], 32'd252); end
      vectors++;
      if (ReadData[DW +: DW] !== 32'd0) begin errors++; $display("FAIL reset_r5: got %h want 0", ReadData[DW +: DW]); end
      vectors++;
      if (ReadBusy !== 2'b00 || PendingAny !== 1'b0) begin errors++; $display("FAIL reset_sb: busy=%b pend=%b want 00/0", ReadBusy, PendingAny); end
   endtask

   task automatic test_forward_a();
      idle();
      RegWriteA = 1; WriteRegisterA = 8; WriteDataA = 32'hDEADBEEF;
      set_read(0, 8);
      tick();
      vectors++;
      if (ReadData[0 +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_a: got %h want deadbeef", ReadData[0 +: DW]); end
      idle();
      set_read(1, 8);
      tick();
      vectors++;
      if (ReadData[DW +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_a: got %h want deadbeef", ReadData[DW +: DW]); end
   endtask

   task automatic test_ab_collision();
      idle();
      RegWriteA = 1; WriteRegisterA = 12; WriteDataA = 32'h1111;
      RegWriteB = 1; WriteRegisterB = 12; WriteDataB = 32'h2222;
      set_read(0, 12);
      set_read(1, 12);
      tick();
      vectors++;
      if (ReadData !== {32'h2222, 32'h2222}) begin errors++; $display("FAIL ab_fwd: got %h want 0000222200002222", ReadData); end
      idle();
      set_read(0, 12);
      tick();
      vectors++;
      if (ReadData[0 +: DW] !== 32'h2222) begin errors++; $display("FAIL ab_stored: got %h want 2222", ReadData[0 +: DW]); end
   endtask

   task automatic test_scoreboard();
      idle();
      Reserve = 1; ReserveRegister = 9;
      set_read(0, 9);
      tick();
      vectors++;
      if (ReadBusy[0] !== 1'b1 || PendingAny !== 1'b1) begin errors++; $display("FAIL sb_set: busy=%b pend=%b want 1/1", ReadBusy[0], PendingAny); end
      RegWriteB = 1; WriteRegisterB = 9; WriteDataB = 32'h55;
      tick();
      vectors++;
      if (ReadBusy[0] !== 1'b1 || ReadData[0 +: DW] !== 32'h55 || PendingAny !== 1'b1) begin
         errors++;
         $display("FAIL sb_set_clear: busy=%b data=%h pend=%b want 1/55/1", ReadBusy[0], ReadData[0 +: DW], PendingAny);
      end
      Reserve = 0; WriteDataB = 32'h66;
      tick();
      vectors++;
      if (ReadBusy[0] !== 1'b0 || ReadData[0 +: DW] !== 32'h66 || PendingAny !== 1'b0) begin
         errors++;
         $display("FAIL sb_clear: busy=%b data=%h pend=%b want 0/66/0", ReadBusy[0], ReadData[0 +: DW], PendingAny);
      end
   endtask

   task automatic test_zero_reg();
      idle();
      RegWriteA = 1; WriteRegisterA = 0; WriteDataA = 32'hFFFF_FFFF;
      RegWriteB = 1; WriteRegisterB = 0; WriteDataB = 32'hA5A5_A5A5;
      Reserve = 1; ReserveRegister = 0;
      set_read(0, 0);
      set_read(1, 0);
      tick();
      vectors++;
      if (ReadData !== '0 || ReadBusy !== 2'b00 || PendingAny !== 1'b0) begin
         errors++;
         $display("FAIL zero_reg: data=%h busy=%b pend=%b want 0/00/0", ReadData, ReadBusy, PendingAny);
      end
   endtask

   task automatic test_hold();
      idle();
      set_read(1, 29);
      tick();
      idle();
      RegWriteA = 1; WriteRegisterA = 29; WriteDataA = 32'h1234;
      ReadRegister[AW +: AW] = 5'd8;
      tick();
      vectors++;
      if (ReadData[DW +: DW] !== 32'd252) begin errors++; $display("FAIL hold: got %h want fc", ReadData[DW +: DW]); end
   endtask

   task automatic test_reset_mid();
      idle();
      RegWriteA = 1; WriteRegisterA = 20; WriteDataA = 32'h77;
      Reserve = 1; ReserveRegister = 20;
      tick();
      idle();
      set_read(0, 20);
      tick();
      vectors++;
      if (ReadData[0 +: DW] !== 32'h77 || ReadBusy[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup: data=%h busy=%b want 77/1", ReadData[0 +: DW], ReadBusy[0]);
      end
      RegWriteB = 1; WriteRegisterB = 21; WriteDataB = 32'h99;
      #2;
      Reset_n = 1'b0;
      #1;
      vectors++;
      if (ReadData !== '0 || ReadBusy !== '0 || PendingAny !== 1'b0) begin
         errors++;
         $display("FAIL mid_async: data=%h busy=%b pend=%b want 0/0/0", ReadData, ReadBusy, PendingAny);
      end
      @(negedge Clk);
      idle();
      model_reset();
      Reset_n = 1'b1;
      set_read(0, 20);
      set_read(1, 21);
      tick();
      vectors++;
      if (ReadData !== '0 || ReadBusy !== 2'b00 || PendingAny !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: data=%h busy=%b pend=%b want 0/00/0", ReadData, ReadBusy, PendingAny);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 500; n++) begin
         RegWriteA = 1'($urandom_range(0, 1));
         WriteRegisterA = AW'($urandom_range(0, 11));
         WriteDataA = $urandom;
         RegWriteB = ($urandom_range(0, 3) == 0);
         WriteRegisterB = AW'($urandom_range(0, 11));
         WriteDataB = $urandom;
         Reserve = ($urandom_range(0, 2) == 0);
         ReserveRegister = AW'($urandom_range(0, 11));
         for (int i = 0; i < NRD; i++) begin
            ReadRegister[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 11));
            ReadEnable[i] = ($urandom_range(0, 4) != 0);
         end
         tick();
         for (int i = 0; i < NRD; i++) begin
            vectors++;
            if (ReadData[i*DW +: DW] !== m_rd[i] || ReadBusy[i] !== m_busy[i]) begin
               errors++;
               $display("FAIL rand_port%0d cycle %0d: data=%h busy=%b want %h/%b", i, n, ReadData[i*DW +: DW], ReadBusy[i], m_rd[i], m_busy[i]);
            end
         end
         vectors++;
         if (PendingAny !== m_pend) begin errors++; $display("FAIL rand_pend cycle %0d: got %b want %b", n, PendingAny, m_pend); end
      end
   endtask

   initial begin
      test_reset();
      test_forward_a();
      test_ab_collision();
      test_scoreboard();
      test_zero_reg();
      test_hold();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
